// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline. Builds the
//                per-stage hold mask, takes MEM exceptions/ERET and holds the
//                PC redirect until fetch accepts it. Saturating perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int                STALL_W    = 6,
    parameter int                EXC_W      = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'hBFC00380,
    parameter int                CNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic [EXC_W-1:0]   mem_exception_type,
    input  logic               mem_is_eret,
    input  logic [ADDR_W-1:0]  cp0_epc,
    input  logic               if_ack,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [ADDR_W-1:0]  new_pc,
    output logic               new_pc_valid,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_count
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    localparam logic [STALL_W-1:0] c_pc_hold = {{(STALL_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [ADDR_W-1:0]   r_new_pc;
    logic                r_new_pc_valid;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [CNT_W-1:0]    r_flush_count;

    logic                w_exc;
    logic                w_take;
    logic                w_any_req;
    logic [2:0]          w_level;
    logic [STALL_W-1:0]  w_run_mask;
    logic [STALL_W-1:0]  w_stall;

    assign w_exc  = (|mem_exception_type) | mem_is_eret;
    // A MEM stall defers the exception until the faulting access completes.
    assign w_take = ~reset & (r_state == ST_RUN) & w_exc & ~stallreq_mem;

    always_comb begin
        w_any_req  = 1'b1;
        w_level    = 3'd0;
        w_run_mask = '0;
        if (stallreq_mem)      w_level = 3'd4;
        else if (stallreq_ex)  w_level = 3'd3;
        else if (stallreq_id)  w_level = 3'd2;
        else if (stallreq_if)  w_level = 3'd1;
        else                   w_any_req = 1'b0;
        for (int i = 0; i < STALL_W; i++) begin
            w_run_mask[i] = w_any_req && (i <= int'(w_level));
        end
    end

    always_comb begin
        w_stall = '0;
        if (reset)                        w_stall = '0;
        else if (r_state == ST_REDIRECT)  w_stall = c_pc_hold;
        else if (w_take)                  w_stall = '0;
        else                              w_stall = w_run_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_new_pc       <= '0;
            r_new_pc_valid <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_take) begin
                        r_state        <= ST_REDIRECT;
                        r_new_pc       <= mem_is_eret ? cp0_epc : EXC_VECTOR;
                        r_new_pc_valid <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (if_ack) begin
                        r_state        <= ST_RUN;
                        r_new_pc_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_RUN;
            endcase

            if ((|w_stall) && (r_stall_cycles != c_cnt_max)) begin
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
            end
            if (w_take && (r_flush_count != c_cnt_max)) begin
                r_flush_count <= r_flush_count + c_cnt_one;
            end
        end
    end

    assign stall        = w_stall;
    assign flush        = w_take;
    assign new_pc       = r_new_pc;
    assign new_pc_valid = r_new_pc_valid;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed self-checking bench for pipe_ctrl (CNT_W = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] mem_exception_type;
    logic        mem_is_eret;
    logic [31:0] cp0_epc;
    logic        if_ack;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        new_pc_valid;
    logic [3:0]  stall_cycles;
    logic [3:0]  flush_count;

    int n_vec = 0;
    int n_err = 0;

    pipe_ctrl #(.CNT_W(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .stallreq_if        (stallreq_if),
        .stallreq_id        (stallreq_id),
        .stallreq_ex        (stallreq_ex),
        .stallreq_mem       (stallreq_mem),
        .mem_exception_type (mem_exception_type),
        .mem_is_eret        (mem_is_eret),
        .cp0_epc            (cp0_epc),
        .if_ack             (if_ack),
        .stall              (stall),
        .flush              (flush),
        .new_pc             (new_pc),
        .new_pc_valid       (new_pc_valid),
        .stall_cycles       (stall_cycles),
        .flush_count        (flush_count)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        stallreq_if        = 1'b0;
        stallreq_id        = 1'b0;
        stallreq_ex        = 1'b0;
        stallreq_mem       = 1'b0;
        mem_exception_type = '0;
        mem_is_eret        = 1'b0;
        cp0_epc            = '0;
        if_ack             = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        stallreq_mem = 1'b1;
        mem_exception_type = 32'h1;
        #1;
        n_vec++;
        if (stall !== 6'b000000) begin
            n_err++; $display("FAIL reset_stall: got %b want %b", stall, 6'b000000);
        end
        n_vec++;
        if (flush !== 1'b0) begin
            n_err++; $display("FAIL reset_flush: got %b want 0", flush);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if ({new_pc_valid, new_pc, stall_cycles, flush_count} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_regs: valid=%b pc=%h sc=%h fc=%h want all 0",
                     new_pc_valid, new_pc, stall_cycles, flush_count);
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_redirect();
        apply_reset();
        mem_exception_type = 32'h1;
        @(negedge clk);
        mem_exception_type = 32'h0;
        #1;
        n_vec++;
        if (new_pc_valid !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre_valid: got %b want 1", new_pc_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if ({new_pc_valid, stall, stall_cycles, flush_count} !== 15'd0) begin
            n_err++;
            $display("FAIL midrst_clear: valid=%b stall=%b sc=%h fc=%h want all 0",
                     new_pc_valid, stall, stall_cycles, flush_count);
        end
        @(negedge clk);
        stallreq_id = 1'b1;
        #1;
        n_vec++;
        if (stall !== 6'b000111) begin
            n_err++; $display("FAIL midrst_run_state: stall=%b want %b", stall, 6'b000111);
        end
        stallreq_id = 1'b0;
    endtask

    task automatic test_priority();
        apply_reset();
        stallreq_id = 1'b1;
        stallreq_ex = 1'b1;
        #1;
        n_vec++;
        if (stall !== 6'b001111) begin
            n_err++; $display("FAIL prio_id_ex: stall=%b want %b", stall, 6'b001111);
        end
        @(negedge clk);
        stallreq_id = 1'b0;
        stallreq_ex = 1'b0;
        stallreq_if = 1'b1;
        #1;
        n_vec++;
        if (stall !== 6'b000011) begin
            n_err++; $display("FAIL prio_if: stall=%b want %b", stall, 6'b000011);
        end
        @(negedge clk);
        stallreq_if = 1'b0;
        #1;
        n_vec++;
        if (stall !== 6'b000000 || stall_cycles !== 4'd2) begin
            n_err++; $display("FAIL prio_none: stall=%b sc=%0d want 000000 / 2", stall, stall_cycles);
        end
        apply_reset();
        stallreq_mem = 1'b1;
        stallreq_if  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            n_vec++;
            if (stall !== 6'b011111) begin
                n_err++; $display("FAIL prio_mem[%0d]: stall=%b want %b", k, stall, 6'b011111);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_vec++;
        if (stall_cycles !== 4'd3) begin
            n_err++; $display("FAIL prio_mem_count: sc=%0d want 3", stall_cycles);
        end
    endtask

    task automatic test_exception();
        apply_reset();
        mem_exception_type = 32'h1;
        stallreq_ex = 1'b1;
        #1;
        n_vec++;
        if (flush !== 1'b1 || stall !== 6'b000000 || new_pc_valid !== 1'b0) begin
            n_err++; $display("FAIL exc_take: flush=%b stall=%b valid=%b want 1/000000/0",
                              flush, stall, new_pc_valid);
        end
        @(negedge clk);
        stallreq_ex = 1'b0;
        stallreq_id = 1'b1;
        mem_exception_type = 32'h2;
        #1;
        n_vec++;
        if (new_pc !== 32'hBFC00380 || new_pc_valid !== 1'b1) begin
            n_err++; $display("FAIL exc_redirect: pc=%h valid=%b want bfc00380/1", new_pc, new_pc_valid);
        end
        n_vec++;
        if (stall !== 6'b000001 || flush !== 1'b0) begin
            n_err++; $display("FAIL exc_hold: stall=%b flush=%b want 000001/0", stall, flush);
        end
        @(negedge clk);
        mem_exception_type = 32'h0;
        stallreq_id = 1'b0;
        if_ack = 1'b1;
        #1;
        n_vec++;
        if (new_pc_valid !== 1'b1 || stall !== 6'b000001) begin
            n_err++; $display("FAIL exc_hold2: valid=%b stall=%b want 1/000001", new_pc_valid, stall);
        end
        @(negedge clk);
        if_ack = 1'b0;
        #1;
        n_vec++;
        if (new_pc_valid !== 1'b0 || stall !== 6'b000000) begin
            n_err++; $display("FAIL exc_ack: valid=%b stall=%b want 0/000000", new_pc_valid, stall);
        end
        n_vec++;
        if (flush_count !== 4'd1 || stall_cycles !== 4'd2) begin
            n_err++; $display("FAIL exc_counts: fc=%0d sc=%0d want 1/2", flush_count, stall_cycles);
        end
    endtask

    task automatic test_eret();
        apply_reset();
        for (int j = 0; j < 2; j++) begin
            mem_is_eret = 1'b1;
            cp0_epc = 32'h80001234;
            mem_exception_type = (j == 0) ? 32'h0 : 32'h4;
            #1;
            n_vec++;
            if (flush !== 1'b1) begin
                n_err++; $display("FAIL eret_flush[%0d]: flush=%b want 1", j, flush);
            end
            @(negedge clk);
            mem_is_eret = 1'b0;
            mem_exception_type = 32'h0;
            cp0_epc = 32'h0;
            if_ack = 1'b1;
            #1;
            n_vec++;
            if (new_pc !== 32'h80001234 || new_pc_valid !== 1'b1) begin
                n_err++; $display("FAIL eret_pc[%0d]: pc=%h valid=%b want 80001234/1", j, new_pc, new_pc_valid);
            end
            @(negedge clk);
            if_ack = 1'b0;
        end
        #1;
        n_vec++;
        if (flush_count !== 4'd2 || new_pc_valid !== 1'b0 || new_pc !== 32'h80001234) begin
            n_err++; $display("FAIL eret_done: fc=%0d valid=%b pc=%h want 2/0/80001234",
                              flush_count, new_pc_valid, new_pc);
        end
    endtask

    task automatic test_deferred();
        apply_reset();
        mem_exception_type = 32'h1;
        stallreq_mem = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            n_vec++;
            if (flush !== 1'b0 || stall !== 6'b011111) begin
                n_err++; $display("FAIL defer_hold[%0d]: flush=%b stall=%b want 0/011111", k, flush, stall);
            end
        end
        @(negedge clk);
        stallreq_mem = 1'b0;
        #1;
        n_vec++;
        if (flush !== 1'b1 || stall !== 6'b000000) begin
            n_err++; $display("FAIL defer_take: flush=%b stall=%b want 1/000000", flush, stall);
        end
        @(negedge clk);
        mem_exception_type = 32'h0;
        if_ack = 1'b1;
        #1;
        n_vec++;
        if (new_pc !== 32'hBFC00380 || new_pc_valid !== 1'b1) begin
            n_err++; $display("FAIL defer_redirect: pc=%h valid=%b want bfc00380/1", new_pc, new_pc_valid);
        end
        @(negedge clk);
        if_ack = 1'b0;
        #1;
        n_vec++;
        if (stall_cycles !== 4'd3 || flush_count !== 4'd1 || new_pc_valid !== 1'b0) begin
            n_err++; $display("FAIL defer_counts: sc=%0d fc=%0d valid=%b want 3/1/0",
                              stall_cycles, flush_count, new_pc_valid);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        stallreq_mem = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            #1;
            if (k == 14 || k == 15 || k == 19) begin
                n_vec++;
                if (stall_cycles !== ((k == 14) ? 4'hE : 4'hF)) begin
                    n_err++; $display("FAIL sat_stall[%0d]: sc=%h want %h", k, stall_cycles,
                                      (k == 14) ? 4'hE : 4'hF);
                end
            end
        end
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            if_ack = 1'b0;
            mem_exception_type = 32'h8;
            @(negedge clk);
            mem_exception_type = 32'h0;
            if_ack = 1'b1;
            @(negedge clk);
        end
        if_ack = 1'b0;
        #1;
        n_vec++;
        if (flush_count !== 4'hF) begin
            n_err++; $display("FAIL sat_flush: fc=%h want f", flush_count);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_reset_mid_redirect();
        test_priority();
        test_exception();
        test_eret();
        test_deferred();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
